// File: rtl/pong_game_ctrl.sv
// Frame-rate pong sequencer: advances ball and paddle once per frame_tick, resolves
// wall/paddle bounces, keeps score and lives, and runs the serve/play/pause/over flow.
module pong_game_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int WALL_R       = 39,
  parameter int PAD_X_L      = 600,
  parameter int PAD_H        = 72,
  parameter int PAD_V        = 4,
  parameter int BALL_SZ      = 8,
  parameter int BALL_V       = 2,
  parameter int BALL_X0      = 316,
  parameter int BALL_Y0      = 236,
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_y,
  output logic [3:0] score,
  output logic [1:0] lives,
  output logic [2:0] state,
  output logic       gfx_en
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int TW = $clog2(SERVE_FRAMES + 1);

  localparam logic [10:0] MISS_X  = 11'(SCREEN_W - BALL_SZ);
  localparam logic [10:0] LWALL_X = 11'(WALL_R + BALL_V);
  localparam logic [10:0] HIT_LO  = 11'(PAD_X_L - BALL_V);
  localparam logic [10:0] HIT_HI  = 11'(PAD_X_L - 1);
  localparam logic [10:0] BOT_Y   = 11'(SCREEN_H - BALL_SZ - BALL_V);
  localparam logic [10:0] PAD_MAX = 11'(SCREEN_H - PAD_H);
  localparam logic [10:0] STEP_B  = 11'(BALL_V);
  localparam logic [10:0] STEP_P  = 11'(PAD_V);
  localparam logic [10:0] SZ_M1   = 11'(BALL_SZ - 1);
  localparam logic [10:0] PH_M1   = 11'(PAD_H - 1);
  localparam logic [9:0]  X0      = 10'(BALL_X0);
  localparam logic [9:0]  Y0      = 10'(BALL_Y0);
  localparam logic [9:0]  PAD0    = 10'((SCREEN_H - PAD_H) / 2);
  localparam logic [1:0]  LIVES0  = 2'(LIVES);
  localparam logic [TW-1:0] TLAST = TW'(SERVE_FRAMES - 1);

  state_t        st;
  logic          dir_x;       // 1 = moving right
  logic          dir_y;       // 1 = moving down
  logic [TW-1:0] timer;
  logic          start_prev;
  logic          start_pulse;

  logic [10:0] bx, by, py, br, bb, nbx, nby, npy;
  logic        miss, hit, ndx, ndy;

  assign state       = st;
  assign start_pulse = btn_start & ~start_prev;

  // Next-frame candidates, all computed from the pre-tick positions.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    bx   = {1'b0, ball_x};
    by   = {1'b0, ball_y};
    py   = {1'b0, paddle_y};
    br   = bx + SZ_M1;
    bb   = by + SZ_M1;
    miss = (bx >= MISS_X);
    hit  = dir_x && (br >= HIT_LO) && (br <= HIT_HI) && (bb >= py) && (by <= py + PH_M1);
    ndx  = dir_x;
    if (bx <= LWALL_X) ndx = 1'b1;
    if (hit)           ndx = 1'b0;
    ndy  = dir_y;
    if (by < STEP_B) ndy = 1'b1;
    if (by > BOT_Y)  ndy = 1'b0;
    nbx  = ndx ? bx + STEP_B : bx - STEP_B;
    nby  = ndy ? by + STEP_B : by - STEP_B;
    npy  = py;
    if (btn_up && !btn_down)
      npy = (py >= STEP_P) ? py - STEP_P : 11'd0;
    else if (btn_down && !btn_up)
      npy = (py + STEP_P >= PAD_MAX) ? PAD_MAX : py + STEP_P;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      st         <= S_IDLE;
      ball_x     <= X0;
      ball_y     <= Y0;
      dir_x      <= 1'b0;
      dir_y      <= 1'b1;
      paddle_y   <= PAD0;
      score      <= 4'd0;
      lives      <= LIVES0;
      timer      <= '0;
      gfx_en     <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      start_prev <= btn_start;
      case (st)
        S_IDLE, S_OVER: begin
          if (start_pulse) begin
            st     <= S_SERVE;
            score  <= 4'd0;
            lives  <= LIVES0;
            ball_x <= X0;
            ball_y <= Y0;
            dir_x  <= 1'b0;
            dir_y  <= 1'b1;
            timer  <= '0;
            gfx_en <= 1'b1;
          end
        end
        S_SERVE: begin
          if (frame_tick) begin
            paddle_y <= npy[9:0];
            if (timer == TLAST) begin
              st    <= S_PLAY;
              timer <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
        end
        S_PLAY: begin
          if (start_pulse) begin
            st <= S_PAUSE;
          end else if (frame_tick) begin
            if (miss) begin
              if (lives == 2'd1) begin
                lives  <= 2'd0;
                st     <= S_OVER;
                gfx_en <= 1'b0;
              end else begin
                lives  <= lives - 2'd1;
                st     <= S_SERVE;
                ball_x <= X0;
                ball_y <= Y0;
                dir_x  <= 1'b0;
                dir_y  <= 1'b1;
                timer  <= '0;
              end
            end else begin
              dir_x    <= ndx;
              dir_y    <= ndy;
              ball_x   <= nbx[9:0];
              ball_y   <= nby[9:0];
              paddle_y <= npy[9:0];
              if (hit && score != 4'hF) score <= score + 4'd1;
            end
          end
        end
        S_PAUSE: begin
          if (start_pulse) st <= S_PLAY;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed scenarios plus randomized play,
// checked against an integer game model that follows the game rules directly.
module tb_pong_game_ctrl;

  localparam int SCREEN_W = 640, SCREEN_H = 480, WALL_R = 39, PAD_X_L = 600;
  localparam int PAD_H = 72, PAD_V = 4, BALL_SZ = 8, BALL_V = 2;
  localparam int BALL_X0 = 316, BALL_Y0 = 236, LIVES = 3, SERVE_FRAMES = 60;
  localparam int IDLE = 0, SERVE = 1, PLAY = 2, PAUSE = 3, OVER = 4;

  logic       clock = 1'b0;
  logic       reset, frame_tick, btn_up, btn_down, btn_start;
  logic [9:0] ball_x, ball_y, paddle_y;
  logic [3:0] score;
  logic [1:0] lives;
  logic [2:0] state;
  logic       gfx_en;

  int checks = 0;
  int errors = 0;

  // Game model: positions as plain integers, directions as +1/-1.
  int mstate, mbx, mby, mdx, mdy, mpad, mscore, mlives, mtimer;
  bit mprev, mhit, mmiss;

  pong_game_ctrl dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_start(btn_start),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_y(paddle_y),
    .score(score), .lives(lives), .state(state), .gfx_en(gfx_en)
  );

  always #5 clock = ~clock;

  wire [39:0] dvec = {ball_x, ball_y, paddle_y, score, lives, state, gfx_en};

  function automatic logic [39:0] mvec();
    return {10'(mbx), 10'(mby), 10'(mpad), 4'(mscore), 2'(mlives), 3'(mstate),
            (mstate >= SERVE && mstate <= PAUSE)};
  endfunction

  task automatic serve_ball();
    mbx = BALL_X0; mby = BALL_Y0; mdx = -1; mdy = 1;
  endtask

  task automatic model_reset();
    mstate = IDLE; serve_ball(); mpad = (SCREEN_H - PAD_H) / 2;
    mscore = 0; mlives = LIVES; mtimer = 0; mprev = 0;
  endtask

  task automatic model_paddle(input bit up, input bit dn);
    if (up && !dn)      mpad = (mpad - PAD_V < 0) ? 0 : mpad - PAD_V;
    else if (dn && !up) mpad = (mpad + PAD_V > SCREEN_H - PAD_H) ? SCREEN_H - PAD_H : mpad + PAD_V;
  endtask

  task automatic model_frame(input bit up, input bit dn);
    if (mbx >= SCREEN_W - BALL_SZ) begin
      mmiss = 1;
      if (mlives == 1) begin
        mlives = 0; mstate = OVER;
      end else begin
        mlives--; mstate = SERVE; serve_ball(); mtimer = 0;
      end
      return;
    end
    if (mbx <= WALL_R + BALL_V) mdx = 1;
    if (mdx == 1 && mbx + BALL_SZ - 1 >= PAD_X_L - BALL_V && mbx + BALL_SZ - 1 <= PAD_X_L - 1 &&
        mby + BALL_SZ - 1 >= mpad && mby <= mpad + PAD_H - 1) begin
      mdx = -1; mhit = 1;
      if (mscore < 15) mscore++;
    end
    if (mby < BALL_V) mdy = 1;
    if (mby > SCREEN_H - BALL_SZ - BALL_V) mdy = -1;
    mbx += BALL_V * mdx;
    mby += BALL_V * mdy;
    model_paddle(up, dn);
  endtask

  task automatic model_step(input bit up, input bit dn, input bit st, input bit tk, input bit rst);
    bit sp;
    mhit = 0; mmiss = 0;
    if (rst) begin
      model_reset();
      return;
    end
    sp = st && !mprev;
    mprev = st;
    case (mstate)
      IDLE, OVER: if (sp) begin
        mstate = SERVE; mscore = 0; mlives = LIVES; serve_ball(); mtimer = 0;
      end
      SERVE: if (tk) begin
        model_paddle(up, dn);
        if (mtimer == SERVE_FRAMES - 1) begin mstate = PLAY; mtimer = 0; end
        else mtimer++;
      end
      PLAY: begin
        if (sp) mstate = PAUSE;
        else if (tk) model_frame(up, dn);
      end
      PAUSE: if (sp) mstate = PLAY;
      default: ;
    endcase
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input bit up, input bit dn, input bit st, input bit tk, input bit rst = 0);
    btn_up = up; btn_down = dn; btn_start = st; frame_tick = tk; reset = rst;
    model_step(up, dn, st, tk, rst);
    @(posedge clock);
    #1;
  endtask

  task automatic frame(input bit up, input bit dn);
    cyc(up, dn, 0, 1);
    cyc(up, dn, 0, 0);
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (dvec !== {10'd316, 10'd236, 10'd204, 4'd0, 2'd3, 3'd0, 1'b0}) begin
      errors++; $display("FAIL reset_values: got %h expected %h", dvec,
                         {10'd316, 10'd236, 10'd204, 4'd0, 2'd3, 3'd0, 1'b0});
    end
  endtask

  task automatic test_start_serve();
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    checks++;
    if (state !== 3'd1 || gfx_en !== 1'b1) begin
      errors++; $display("FAIL serve_entry: got state %0d gfx %b expected 1 1", state, gfx_en);
    end
    for (int i = 0; i < 59; i++) frame(0, 0);
    checks++;
    if (state !== 3'd1 || ball_x !== 10'd316 || ball_y !== 10'd236) begin
      errors++; $display("FAIL serve_hold: got state %0d ball %0d,%0d expected 1 316,236",
                         state, ball_x, ball_y);
    end
    frame(0, 0);
    checks++;
    if (state !== 3'd2) begin
      errors++; $display("FAIL serve_to_play: got %0d expected 2", state);
    end
    frame(0, 0);
    checks++;
    if (ball_x !== 10'd314 || ball_y !== 10'd238) begin
      errors++; $display("FAIL first_play_tick: got %0d,%0d expected 314,238", ball_x, ball_y);
    end
  endtask

  task automatic test_paddle();
    for (int i = 0; i < 51; i++) frame(1, 0);
    checks++;
    if (paddle_y !== 10'd0) begin
      errors++; $display("FAIL paddle_top: got %0d expected 0", paddle_y);
    end
    for (int i = 0; i < 3; i++) frame(1, 0);
    checks++;
    if (paddle_y !== 10'd0) begin
      errors++; $display("FAIL paddle_top_hold: got %0d expected 0", paddle_y);
    end
    for (int i = 0; i < 104; i++) frame(0, 1);
    checks++;
    if (paddle_y !== 10'd408) begin
      errors++; $display("FAIL paddle_bottom_cap: got %0d expected 408", paddle_y);
    end
    for (int i = 0; i < 5; i++) frame(1, 1);
    checks++;
    if (paddle_y !== 10'd408) begin
      errors++; $display("FAIL paddle_both: got %0d expected 408", paddle_y);
    end
    checks++;
    if (dvec !== mvec()) begin
      errors++; $display("FAIL paddle_model: got %h expected %h", dvec, mvec());
    end
  endtask

  task automatic test_hits();
    int hits = 0;
    for (int t = 0; t < 20000 && hits < 16; t++) begin
      int tgt, pre_x, pre_s;
      bit up, dn;
      tgt = mby - 32;
      if (tgt < 0) tgt = 0;
      if (tgt > SCREEN_H - PAD_H) tgt = SCREEN_H - PAD_H;
      up = (mpad > tgt + 3);
      dn = (mpad < tgt - 3);
      pre_x = mbx; pre_s = mscore;
      cyc(up, dn, 0, 1);
      if (mhit) begin
        hits++;
        checks++;
        if (score !== 4'((pre_s == 15) ? 15 : pre_s + 1) || ball_x !== 10'(pre_x - BALL_V)) begin
          errors++; $display("FAIL paddle_hit: got score %0d x %0d expected %0d %0d", score, ball_x,
                             (pre_s == 15) ? 15 : pre_s + 1, pre_x - BALL_V);
        end
      end
      checks++;
      if (dvec !== mvec()) begin
        errors++; $display("FAIL hit_track: got %h expected %h", dvec, mvec());
      end
      cyc(up, dn, 0, 0);
    end
    checks++;
    if (hits != 16) begin
      errors++; $display("FAIL hit_timeout: got %0d hits expected 16", hits);
    end
    checks++;
    if (score !== 4'd15 || lives !== 2'd3) begin
      errors++; $display("FAIL hit_saturate: got score %0d lives %0d expected 15 3", score, lives);
    end
  endtask

  task automatic test_misses();
    int misses = 0;
    for (int t = 0; t < 10000 && mstate != OVER; t++) begin
      bit up, dn;
      // Steer the paddle to the half away from the ball, with some random jitter.
      up = (mby >= SCREEN_H / 2 - 32);
      dn = !up;
      if ($urandom_range(3) == 0) begin up = 1'($urandom); dn = 1'($urandom); end
      cyc(up, dn, 0, 1);
      checks++;
      if (dvec !== mvec()) begin
        errors++; $display("FAIL miss_track: got %h expected %h", dvec, mvec());
      end
      if (mmiss) begin
        misses++;
        checks++;
        if (lives !== 2'(LIVES - misses) || state !== 3'((misses == LIVES) ? OVER : SERVE) ||
            score !== 4'd15) begin
          errors++; $display("FAIL miss_event: got lives %0d state %0d score %0d expected %0d %0d 15",
                             lives, state, score, LIVES - misses, (misses == LIVES) ? OVER : SERVE);
        end
      end
      cyc(up, dn, 0, 0);
    end
    checks++;
    if (state !== 3'd4 || gfx_en !== 1'b0 || lives !== 2'd0 || misses != 3) begin
      errors++; $display("FAIL game_over: got state %0d gfx %b lives %0d misses %0d expected 4 0 0 3",
                         state, gfx_en, lives, misses);
    end
    for (int i = 0; i < 3; i++) frame(1, 0);
    checks++;
    if (dvec !== mvec()) begin
      errors++; $display("FAIL over_ignores_tick: got %h expected %h", dvec, mvec());
    end
    cyc(0, 0, 1, 0);
    checks++;
    if (state !== 3'd1 || score !== 4'd0 || lives !== 2'd3 || gfx_en !== 1'b1 ||
        ball_x !== 10'd316 || ball_y !== 10'd236) begin
      errors++; $display("FAIL restart: got state %0d score %0d lives %0d gfx %b ball %0d,%0d expected 1 0 3 1 316,236",
                         state, score, lives, gfx_en, ball_x, ball_y);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_pause();
    int fx, fy, fp;
    for (int i = 0; i < 65; i++) frame(0, 0);
    checks++;
    if (state !== 3'd2) begin
      errors++; $display("FAIL pause_setup: got %0d expected 2", state);
    end
    fx = mbx; fy = mby; fp = mpad;
    cyc(1, 0, 1, 1);
    checks++;
    if (state !== 3'd3 || ball_x !== 10'(fx) || ball_y !== 10'(fy) || paddle_y !== 10'(fp)) begin
      errors++; $display("FAIL pause_wins: got state %0d ball %0d,%0d pad %0d expected 3 %0d,%0d %0d",
                         state, ball_x, ball_y, paddle_y, fx, fy, fp);
    end
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      frame(1'($urandom), 1'($urandom));
      checks++;
      if (state !== 3'd3 || ball_x !== 10'(fx) || ball_y !== 10'(fy) || paddle_y !== 10'(fp)) begin
        errors++; $display("FAIL pause_frozen: got state %0d ball %0d,%0d pad %0d expected 3 %0d,%0d %0d",
                           state, ball_x, ball_y, paddle_y, fx, fy, fp);
      end
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    checks++;
    if (state !== 3'd2 || ball_x !== 10'(fx)) begin
      errors++; $display("FAIL resume: got state %0d x %0d expected 2 %0d", state, ball_x, fx);
    end
    frame(0, 0);
    checks++;
    if (dvec !== mvec() || (ball_x !== 10'(fx - 2) && ball_x !== 10'(fx + 2))) begin
      errors++; $display("FAIL resume_motion: got %h expected %h", dvec, mvec());
    end
  endtask

  task automatic test_reset_mid_play();
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      frame(1, 0);
      checks++;
      if (dvec !== {10'd316, 10'd236, 10'd204, 4'd0, 2'd3, 3'd0, 1'b0}) begin
        errors++; $display("FAIL reset_mid_play: got %h expected %h", dvec,
                           {10'd316, 10'd236, 10'd204, 4'd0, 2'd3, 3'd0, 1'b0});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6000; i++) begin
      cyc(1'($urandom), 1'($urandom), ($urandom_range(63) == 0), 1'($urandom),
          ($urandom_range(1999) == 0));
      checks++;
      if (dvec !== mvec()) begin
        errors++; $display("FAIL random_%0d: got %h expected %h", i, dvec, mvec());
      end
    end
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_start = 1'b0;
    model_reset();
    test_reset();
    test_start_serve();
    test_paddle();
    test_hits();
    test_misses();
    test_pause();
    test_reset_mid_play();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Frame-rate game sequencer for the pong display pipeline.
- Once per video frame it advances the ball and paddle positions, resolves wall and paddle bounces, and tracks score and lives.
- It also runs the serve/play/pause/game-over state machine.
- Its registered position outputs feed the object renderer in place of fixed constants; gfx_en gates ball drawing.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- WALL_R, 39, rightmost x of left wall
- PAD_X_L, 600, paddle left x (paddle right x = PAD_X_L+3)
- PAD_H, 72, paddle height
- PAD_V, 4, paddle step per frame
- BALL_SZ, 8, ball square side
- BALL_V, 2, ball step per axis per frame
- BALL_X0, 316, serve x
- BALL_Y0, 236, serve y
- LIVES, 3, lives per game
- SERVE_FRAMES, 60, frames held in SERVE

Ports:
- clock, in, 1, system/pixel clock
- reset, in, 1, synchronous active-high reset
- frame_tick, in, 1, one-cycle pulse per frame at start of vertical blanking
- btn_up, in, 1, paddle up, level, already synchronised and debounced
- btn_down, in, 1, paddle down, level
- btn_start, in, 1, start/pause, level
- ball_x, out, 10, ball left x
- ball_y, out, 10, ball top y
- paddle_y, out, 10, paddle top y
- score, out, 4, paddle hits, saturating
- lives, out, 2, remaining lives
- state, out, 3, IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4
- gfx_en, out, 1, ball visible

Behaviour:
- Single clock; reset is synchronous, active-high, and highest priority.
- Reset values: state IDLE; ball at (BALL_X0, BALL_Y0); dir_x left, dir_y down; paddle_y = (SCREEN_H-PAD_H)/2 = 204; score 0; lives LIVES; timer 0; gfx_en 0.
- All outputs are registered; a change is visible the cycle after the triggering frame_tick or start_pulse.
- start_pulse: rising edge of btn_start, via a one-flop history that resets to 0. Holding btn_start gives exactly one pulse.
- IDLE/OVER: start_pulse -> SERVE; score 0, lives LIVES, ball and direction reset, timer 0. frame_tick is ignored.
- SERVE:
  - Ball is parked; paddle moves.
  - Each frame_tick increments timer.
  - On the tick where timer == SERVE_FRAMES-1: go to PLAY, timer 0.
  - start_pulse is ignored.
- PLAY, start_pulse: go to PAUSE. If frame_tick occurs in the same cycle, pause wins and no motion update happens that frame.
- PLAY, frame_tick, evaluated in this order on the pre-tick positions:
  - Paddle collision uses the pre-tick paddle_y.
  - Miss: ball_x >= SCREEN_W-BALL_SZ. If lives == 1: lives 0, state OVER. Otherwise lives-1, state SERVE, ball and direction reset, timer 0. No other update that tick.
  - Left wall: ball_x <= WALL_R+BALL_V -> dir_x right.
  - Paddle hit: dir_x right, and r = ball_x+BALL_SZ-1 in [PAD_X_L-BALL_V, PAD_X_L-1], and ball_y+BALL_SZ-1 >= paddle_y, and ball_y <= paddle_y+PAD_H-1. Effect: dir_x left; score+1, saturating at 15.
  - Top: ball_y < BALL_V -> dir_y down.
  - Bottom: ball_y > SCREEN_H-BALL_SZ-BALL_V -> dir_y up.
  - The x and y flips are independent, so a corner flips both.
  - Ball then moves BALL_V in the new direction on each axis. Use 11-bit intermediate arithmetic; results always stay in 0..SCREEN-BALL_SZ.
- Paddle, on frame_tick in SERVE or PLAY only:
  - up&&!down: paddle_y = max(paddle_y-PAD_V, 0), with no underflow.
  - down&&!up: paddle_y = min(paddle_y+PAD_V, SCREEN_H-PAD_H) = 408 cap.
  - Both or neither pressed: hold.
- PAUSE: everything frozen; start_pulse -> PLAY.
- gfx_en = 1 in SERVE, PLAY and PAUSE.
- Reset mid-game returns to IDLE with all reset values on the next edge.

Test Plan:
- Reset asserted mid-PLAY, then 5 frame_ticks -> state 0, ball (316,236), paddle 204, score 0, lives 3, gfx_en 0, no motion.
- btn_start held 10 cycles -> single SERVE entry. After 60 ticks state=2. First PLAY tick -> ball (314,238).
- Hold btn_up from 204 -> paddle 0 after 51 ticks and stays 0. btn_down -> 408 cap. Both pressed -> unchanged.
- Ball driven to paddle with paddle aligned -> dir_x flips, score +1. Sixteen hits -> score 15, holds.
- Three misses -> lives 3->2->1->0, state OVER, gfx_en 0, score held. start_pulse -> SERVE, score 0, lives 3.
- start_pulse coincident with frame_tick in PLAY -> PAUSE, ball unchanged. 10 ticks -> frozen. start_pulse -> PLAY resumes from the frozen position.
